pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//   Parametrised pipeline control unit; next generation of the 6-stage stall controller.
//   Turns per-stage stall requests into a stall mask over NSTAGE stage registers (bit0 = pc_reg).
//   Adds a registered flush/redirect path and a debug halt/resume handshake.
//   Adds a saturating stall-cycle performance counter.
//   Sits beside pc_reg, if_id, id_ex, ex_mem and mem_wb in the cpu_riscv top.
// PARAMETERS
//   NSTAGE     6   stall mask width; bit i freezes stage register i (0 = pc_reg)
//   FLUSH_CYC  1   cycles flush_o is held per redirect; must be >= 1
//   ADDR_W     32  redirect PC width
//   CNT_W      16  stall performance counter width
// PORTS
//   clk           in   1       clock; all state updates on the rising edge
//   rst           in   1       asynchronous, active-high reset
//   stallreq_i    in   NSTAGE  stall request; bit i set => stages 0..i frozen
//   flush_req_i   in   1       redirect request, sampled on clk
//   flush_pc_i    in   ADDR_W  redirect target, sampled with flush_req_i
//   halt_req_i    in   1       debug halt request (level)
//   cnt_clr_i     in   1       synchronous clear of stall_cnt_o
//   stall_o       out  NSTAGE  per-stage stall mask
//   flush_o       out  1       flush all stage registers and redirect pc
//   new_pc_o      out  ADDR_W  redirect target; valid while flush_o=1
//   halt_ack_o    out  1       pipeline halted and drained
//   stall_cnt_o   out  CNT_W   count of cycles with stall_o[0]=1 in RUN
// BEHAVIOUR
//   Reset (async, rst=1):
//     - state=RUN; stall_o=0, flush_o=0, new_pc_o=0, halt_ack_o=0, stall_cnt_o=0, pend=0.
//     - Outputs clear immediately on rst assertion, not at the next edge.
//   Stall mask (combinational, RUN only):
//     - k = index of highest set bit of stallreq_i; stall_o[j]=1 for all j<=k, 0 for j>k.
//     - If stallreq_i==0, stall_o=0.
//   FSM states: RUN, FLUSH, HALTED. flush_o and halt_ack_o are registered state decodes.
//   RUN:
//     - flush_req_i=1: latch flush_pc_i into new_pc_o, load cnt=FLUSH_CYC-1, go to FLUSH.
//     - Else if halt_req_i=1 and stallreq_i==0: go to HALTED.
//       Halt waits (drains) while any stall request is pending.
//     - Flush has priority over halt in the same cycle.
//   FLUSH:
//     - flush_o=1; stall_o=0 regardless of stallreq_i (flush overrides stall).
//     - New flush_req_i: relatch new_pc_o and reload cnt=FLUSH_CYC-1 (latest redirect wins).
//     - Else cnt!=0: decrement. Else cnt==0: go to RUN.
//     - Result: flush_req_i sampled at edge t gives flush_o=1 for exactly the cycles
//       t+1 .. t+FLUSH_CYC.
//     - halt_req_i is ignored in FLUSH; it is re-evaluated in RUN.
//   HALTED:
//     - stall_o = all ones; halt_ack_o=1.
//     - flush_req_i: latch flush_pc_i into new_pc_o and set pend=1; stay HALTED.
//       A later request overwrites the earlier one.
//     - halt_req_i=0 with pend=1: go to FLUSH, cnt=FLUSH_CYC-1, pend cleared.
//     - halt_req_i=0 with pend=0: go to RUN.
//     - halt_ack_o drops in the cycle after halt_req_i falls.
//   new_pc_o holds its last latched value outside FLUSH.
//   Stall counter:
//     - Increments when state==RUN and stall_o[0]=1; saturates at 2^CNT_W-1 (no wrap).
//     - cnt_clr_i=1 sets it to 0 and has priority over increment.
//     - It does not count in FLUSH or HALTED.
//   All arithmetic is unsigned; the down-counter is $clog2(FLUSH_CYC+1) bits wide.
// TESTING
//   1. NSTAGE=6, RUN, stallreq_i=6'b000100 -> stall_o=6'b000111 same cycle;
//      stallreq_i=6'b001100 -> stall_o=6'b001111; 0 -> stall_o=0.
//   2. FLUSH_CYC=2, flush_req_i=1 and flush_pc_i=0x100 at edge t, stallreq_i=6'b001000 held
//      -> flush_o=1, new_pc_o=0x100, stall_o=0 in cycles t+1,t+2; back in RUN at t+3
//      with stall_o=6'b001111.
//   3. halt_req_i=1 with stallreq_i=6'b000100 for 3 cycles -> halt_ack_o=0;
//      stallreq_i->0 -> halt_ack_o=1, stall_o=6'b111111 next cycle;
//      halt_req_i->0 -> RUN, halt_ack_o=0 next cycle.
//   4. In HALTED: flush_req_i with 0x200, then with 0x300 -> still halted;
//      release -> flush_o=1 with new_pc_o=0x300 for FLUSH_CYC cycles, then RUN.
//   5. CNT_W=4, stallreq_i=6'b000010 held 20 cycles -> stall_cnt_o=15 (saturated);
//      cnt_clr_i pulse together with stall -> stall_cnt_o=0 next cycle.
//   6. Assert rst mid-FLUSH -> flush_o, stall_o, new_pc_o = 0 before next edge;
//      after release, RUN with outputs 0 until a new request.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall mask from per-stage requests, registered flush/redirect,
// debug halt/resume handshake and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int NSTAGE    = 6,
  parameter int FLUSH_CYC = 1,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq_i,
  input  logic              flush_req_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              halt_req_i,
  input  logic              cnt_clr_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              halt_ack_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  localparam int FCW = $clog2(FLUSH_CYC + 1);
  localparam logic [FCW-1:0] FLOAD = FCW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

  state_t            state, state_nxt;
  logic [FCW-1:0]    fcnt, fcnt_nxt;
  logic              pend, pend_nxt;
  logic [NSTAGE-1:0] mask;
  logic              acc;

  // Freezing stage i also freezes every earlier stage, so fill downward from the top request.
  always_comb begin
    mask = '0;
    acc  = 1'b0;
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      acc     = acc | stallreq_i[j];
      mask[j] = acc;
    end
  end

  // rst gates the mask so the combinational output also clears without waiting for an edge.
  always_comb begin
    stall_o = '0;
    if (!rst) begin
      case (state)
        RUN:     stall_o = mask;
        HALTED:  stall_o = '1;
        default: stall_o = '0;
      endcase
    end
  end

  assign flush_o    = (state == FLUSH);
  assign halt_ack_o = (state == HALTED);

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    pend_nxt  = pend;
    case (state)
      RUN: begin
        if (flush_req_i) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FLOAD;
        end else if (halt_req_i && stallreq_i == '0) begin
          state_nxt = HALTED;
        end
      end
      FLUSH: begin
        if (flush_req_i)    fcnt_nxt  = FLOAD;
        else if (fcnt != 0) fcnt_nxt  = fcnt - FCW'(1);
        else                state_nxt = RUN;
      end
      HALTED: begin
        if (flush_req_i) pend_nxt = 1'b1;
        // A redirect arriving in the release cycle is still honoured.
        if (!halt_req_i) begin
          if (pend || flush_req_i) begin
            state_nxt = FLUSH;
            fcnt_nxt  = FLOAD;
            pend_nxt  = 1'b0;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      fcnt        <= '0;
      pend        <= 1'b0;
      new_pc_o    <= '0;
      stall_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      pend  <= pend_nxt;
      if (flush_req_i) new_pc_o <= flush_pc_i;
      if (cnt_clr_i)
        stall_cnt_o <= '0;
      else if (state == RUN && stall_o[0] && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: NSTAGE=6, FLUSH_CYC=2, CNT_W=4.
module tb_pipe_ctrl;
  localparam int NSTAGE = 6, FLUSH_CYC = 2, ADDR_W = 32, CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NSTAGE-1:0] stallreq_i;
  logic              flush_req_i;
  logic [ADDR_W-1:0] flush_pc_i;
  logic              halt_req_i;
  logic              cnt_clr_i;
  logic [NSTAGE-1:0] stall_o;
  logic              flush_o;
  logic [ADDR_W-1:0] new_pc_o;
  logic              halt_ack_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  int total = 0, passed = 0;

  pipe_ctrl #(.NSTAGE(NSTAGE), .FLUSH_CYC(FLUSH_CYC), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .flush_req_i(flush_req_i),
    .flush_pc_i(flush_pc_i), .halt_req_i(halt_req_i), .cnt_clr_i(cnt_clr_i),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .halt_ack_o(halt_ack_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stallreq_i = '0; flush_req_i = 1'b0; flush_pc_i = '0;
    halt_req_i = 1'b0; cnt_clr_i = 1'b0;
    #3;
    total++; if (stall_o !== 6'b0) $display("FAIL reset_stall got %b want 000000", stall_o); else passed++;
    total++; if (flush_o !== 1'b0 || halt_ack_o !== 1'b0) $display("FAIL reset_flags got flush=%b ack=%b want 0 0", flush_o, halt_ack_o); else passed++;
    total++; if (new_pc_o !== 32'h0 || stall_cnt_o !== 4'h0) $display("FAIL reset_regs got pc=%h cnt=%0d want 0 0", new_pc_o, stall_cnt_o); else passed++;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stall_mask();
    stallreq_i = 6'b000100; #1;
    total++; if (stall_o !== 6'b000111) $display("FAIL mask_000100 got %b want 000111", stall_o); else passed++;
    stallreq_i = 6'b001100; #1;
    total++; if (stall_o !== 6'b001111) $display("FAIL mask_001100 got %b want 001111", stall_o); else passed++;
    stallreq_i = 6'b100001; #1;
    total++; if (stall_o !== 6'b111111) $display("FAIL mask_100001 got %b want 111111", stall_o); else passed++;
    stallreq_i = 6'b000001; #1;
    total++; if (stall_o !== 6'b000001) $display("FAIL mask_000001 got %b want 000001", stall_o); else passed++;
    stallreq_i = 6'b000000; #1;
    total++; if (stall_o !== 6'b000000) $display("FAIL mask_zero got %b want 000000", stall_o); else passed++;
    tick();
  endtask

  task automatic test_flush();
    flush_req_i = 1'b1; flush_pc_i = 32'h100; stallreq_i = 6'b001000;
    tick();
    flush_req_i = 1'b0; flush_pc_i = 32'hdead;
    total++; if (flush_o !== 1'b1 || new_pc_o !== 32'h100) $display("FAIL flush_c1 got flush=%b pc=%h want 1 100", flush_o, new_pc_o); else passed++;
    total++; if (stall_o !== 6'b0) $display("FAIL flush_c1_stall got %b want 000000", stall_o); else passed++;
    tick();
    total++; if (flush_o !== 1'b1 || stall_o !== 6'b0 || new_pc_o !== 32'h100) $display("FAIL flush_c2 got flush=%b stall=%b pc=%h want 1 000000 100", flush_o, stall_o, new_pc_o); else passed++;
    tick();
    total++; if (flush_o !== 1'b0 || stall_o !== 6'b001111) $display("FAIL flush_end got flush=%b stall=%b want 0 001111", flush_o, stall_o); else passed++;
    total++; if (new_pc_o !== 32'h100) $display("FAIL flush_pc_hold got %h want 100", new_pc_o); else passed++;
    stallreq_i = '0;
    tick();
  endtask

  task automatic test_halt();
    halt_req_i = 1'b1; stallreq_i = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (halt_ack_o !== 1'b0 || stall_o !== 6'b000111) $display("FAIL halt_drain%0d got ack=%b stall=%b want 0 000111", i, halt_ack_o, stall_o); else passed++;
    end
    stallreq_i = '0;
    tick();
    total++; if (halt_ack_o !== 1'b1 || stall_o !== 6'b111111) $display("FAIL halt_enter got ack=%b stall=%b want 1 111111", halt_ack_o, stall_o); else passed++;
    tick();
    total++; if (halt_ack_o !== 1'b1 || flush_o !== 1'b0) $display("FAIL halt_hold got ack=%b flush=%b want 1 0", halt_ack_o, flush_o); else passed++;
    halt_req_i = 1'b0;
    tick();
    total++; if (halt_ack_o !== 1'b0 || stall_o !== 6'b0 || flush_o !== 1'b0) $display("FAIL halt_release got ack=%b stall=%b flush=%b want 0 000000 0", halt_ack_o, stall_o, flush_o); else passed++;
  endtask

  task automatic test_halt_flush();
    halt_req_i = 1'b1;
    tick();
    total++; if (halt_ack_o !== 1'b1) $display("FAIL hf_enter got ack=%b want 1", halt_ack_o); else passed++;
    flush_req_i = 1'b1; flush_pc_i = 32'h200;
    tick();
    total++; if (halt_ack_o !== 1'b1 || flush_o !== 1'b0) $display("FAIL hf_req1 got ack=%b flush=%b want 1 0", halt_ack_o, flush_o); else passed++;
    flush_pc_i = 32'h300;
    tick();
    flush_req_i = 1'b0;
    total++; if (halt_ack_o !== 1'b1 || flush_o !== 1'b0) $display("FAIL hf_req2 got ack=%b flush=%b want 1 0", halt_ack_o, flush_o); else passed++;
    tick();
    total++; if (halt_ack_o !== 1'b1 || flush_o !== 1'b0) $display("FAIL hf_wait got ack=%b flush=%b want 1 0", halt_ack_o, flush_o); else passed++;
    halt_req_i = 1'b0;
    tick();
    total++; if (flush_o !== 1'b1 || new_pc_o !== 32'h300 || halt_ack_o !== 1'b0) $display("FAIL hf_c1 got flush=%b pc=%h ack=%b want 1 300 0", flush_o, new_pc_o, halt_ack_o); else passed++;
    tick();
    total++; if (flush_o !== 1'b1 || new_pc_o !== 32'h300) $display("FAIL hf_c2 got flush=%b pc=%h want 1 300", flush_o, new_pc_o); else passed++;
    tick();
    total++; if (flush_o !== 1'b0 || halt_ack_o !== 1'b0) $display("FAIL hf_run got flush=%b ack=%b want 0 0", flush_o, halt_ack_o); else passed++;
  endtask

  task automatic test_counter();
    cnt_clr_i = 1'b1; stallreq_i = '0;
    tick();
    cnt_clr_i = 1'b0;
    total++; if (stall_cnt_o !== 4'd0) $display("FAIL cnt_clr0 got %0d want 0", stall_cnt_o); else passed++;
    stallreq_i = 6'b000010;
    tick(); tick(); tick();
    total++; if (stall_cnt_o !== 4'd3) $display("FAIL cnt_3 got %0d want 3", stall_cnt_o); else passed++;
    for (int i = 0; i < 17; i++) tick();
    total++; if (stall_cnt_o !== 4'd15) $display("FAIL cnt_sat got %0d want 15", stall_cnt_o); else passed++;
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    total++; if (stall_cnt_o !== 4'd0) $display("FAIL cnt_clr_pri got %0d want 0", stall_cnt_o); else passed++;
    tick();
    total++; if (stall_cnt_o !== 4'd1) $display("FAIL cnt_resume got %0d want 1", stall_cnt_o); else passed++;
    stallreq_i = '0;
    // Flush cycles must not count even with a stall request held.
    flush_req_i = 1'b1; flush_pc_i = 32'h55; stallreq_i = 6'b000001;
    tick();
    flush_req_i = 1'b0;
    tick(); tick();
    total++; if (stall_cnt_o !== 4'd2) $display("FAIL cnt_noflush got %0d want 2", stall_cnt_o); else passed++;
    stallreq_i = '0;
    tick();
  endtask

  task automatic test_reset_mid_flush();
    flush_req_i = 1'b1; flush_pc_i = 32'h444; stallreq_i = 6'b001000;
    tick();
    flush_req_i = 1'b0;
    total++; if (flush_o !== 1'b1) $display("FAIL rmf_inflush got %b want 1", flush_o); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (flush_o !== 1'b0 || stall_o !== 6'b0 || new_pc_o !== 32'h0) $display("FAIL rmf_async got flush=%b stall=%b pc=%h want 0 000000 0", flush_o, stall_o, new_pc_o); else passed++;
    total++; if (stall_cnt_o !== 4'd0) $display("FAIL rmf_cnt got %0d want 0", stall_cnt_o); else passed++;
    stallreq_i = '0;
    tick();
    rst = 1'b0;
    tick();
    total++; if (flush_o !== 1'b0 || stall_o !== 6'b0 || new_pc_o !== 32'h0 || halt_ack_o !== 1'b0) $display("FAIL rmf_after got flush=%b stall=%b pc=%h ack=%b want 0 000000 0 0", flush_o, stall_o, new_pc_o, halt_ack_o); else passed++;
    stallreq_i = 6'b010000; #1;
    total++; if (stall_o !== 6'b011111) $display("FAIL rmf_newreq got %b want 011111", stall_o); else passed++;
    stallreq_i = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_stall_mask();
    test_flush();
    test_halt();
    test_halt_flush();
    test_counter();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
